// File: rtl/crypto_bus_pkg.sv
// Shared definitions for the crypto-side bus arbiters: agent IDs, opcodes, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package crypto_bus_pkg;

    localparam int AGENT_ID_W = 2;

    // Agent IDs double as requester indices on the ack bus.
    localparam logic [AGENT_ID_W-1:0] MEM_ID   = 2'b00;
    localparam logic [AGENT_ID_W-1:0] SHA_ID   = 2'b01;
    localparam logic [AGENT_ID_W-1:0] AES_ID   = 2'b10;
    localparam logic [AGENT_ID_W-1:0] SPARE_ID = 2'b11;

    typedef enum logic [1:0] {
        RD_KEY  = 2'b00,
        RD_TEXT = 2'b01,
        WR_RES  = 2'b10,
        OTHER   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACK     = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    // Round-robin successor of an agent index, wrapping at n.
    function automatic logic [AGENT_ID_W-1:0] rr_next(input logic [AGENT_ID_W-1:0] id,
                                                      input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of mask_i at or after ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   mask_i   - candidate bitmap
//   ptr_i    - index with highest priority this round
//   any_o    - at least one candidate present
//   onehot_o - winner as one-hot (all zero when any_o is low)
//   idx_o    - winner as encoded index (zero when any_o is low)
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        int j;
        j        = 0;
        any_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        // Walk the ring starting at the pointer; the first hit wins.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && mask_i[j]) begin
                any_o       = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = W'(j);
            end
        end
    end

endmodule

// File: rtl/ack_bus_arbiter.sv
// Round-robin arbiter for the shared ack bus: one requester per slot, ID presented to the host.
// Latency: 1 cycle from an eligible req (in IDLE) to host_ack_valid; slots spaced >= 3 cycles.
// Backpressure: valid/id held while host_ack_ready is low, dropped with timeout_err after ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   req            - level request per agent (index = agent ID)
//   owned          - agent's ack is pending or being presented (registered)
//   host_ack_valid - ack slot valid towards the host
//   host_ack_id    - ID of the agent being acknowledged
//   host_ack_ready - host accepts the ack
//   timeout_err    - sticky, set when an ack is dropped on timeout
//   err_clr        - synchronous clear of timeout_err (a simultaneous set wins)
module ack_bus_arbiter
    import crypto_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    owned,
    output logic                  host_ack_valid,
    output logic [AGENT_ID_W-1:0] host_ack_id,
    input  logic                  host_ack_ready,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_e              state_q,    state_d;
    logic [AGENT_ID_W-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
    logic [AGENT_ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [NUM_REQ-1:0]      served_q,   served_d;
    logic [NUM_REQ-1:0]      owned_q,    owned_d;
    logic                    valid_q,    valid_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic                    err_q,      err_d;

    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_any;
    logic [NUM_REQ-1:0]      pick_oh;
    logic [AGENT_ID_W-1:0]   pick_idx;
    logic                    timeout_hit;
    logic                    ack_done;

    // An agent already served stays ineligible until it lowers its request,
    // so a level request left high after delivery is never acked twice.
    assign eligible = req & ~served_q;

    rr_priority_picker #(
        .N (NUM_REQ),
        .W (AGENT_ID_W)
    ) u_pick (
        .mask_i   (eligible),
        .ptr_i    (rr_ptr_q),
        .any_o    (pick_any),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    // Ready takes precedence: an accept on the last allowed cycle is a normal ack.
    assign timeout_hit = (state_q == ACK) && !host_ack_ready && (cnt_q == CNT_LAST);
    assign ack_done    = (state_q == ACK) && (host_ack_ready || timeout_hit);

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        served_d   = served_q & req;
        owned_d    = eligible;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        err_d      = (err_q & ~err_clr) | timeout_hit;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    grant_oh_d = pick_oh;
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = ACK;
                end
            end

            ACK: begin
                // The granted agent keeps ownership even if it drops req;
                // everyone else simply tracks their own eligibility.
                owned_d = (eligible & ~grant_oh_q) | (ack_done ? '0 : grant_oh_q);
                if (ack_done) begin
                    served_d = served_d | grant_oh_q;
                    rr_ptr_d = rr_next(grant_id_q, NUM_REQ);
                    valid_d  = 1'b0;
                    state_d  = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                // One dead cycle on the bus before the next slot.
                valid_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= MEM_ID;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            served_q   <= '0;
            owned_q    <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            served_q   <= served_d;
            owned_q    <= owned_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign owned          = owned_q;
    assign host_ack_valid = valid_q;
    assign host_ack_id    = grant_id_q;
    assign timeout_err    = err_q;

endmodule

// File: tb/tb_ack_bus_arbiter.sv
module tb_ack_bus_arbiter;
    import crypto_bus_pkg::*;

    localparam int M_TO = 64;

    logic       clk;
    logic       rst_n;

    // Main instance, default timeout.
    logic [3:0] req;
    logic [3:0] owned;
    logic       host_ack_valid;
    logic [1:0] host_ack_id;
    logic       host_ack_ready;
    logic       timeout_err;
    logic       err_clr;

    // Short-timeout instance.
    logic [3:0] req_t;
    logic [3:0] owned_t;
    logic       valid_t;
    logic [1:0] id_t;
    logic       ready_t;
    logic       err_t;
    logic       err_clr_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (main instance).
    bit         m_present;
    bit         m_gap;
    int         m_gid;
    int         m_ptr;
    int         m_wait;
    logic [3:0] m_served;
    logic [3:0] m_owned;
    bit         m_err;

    ack_bus_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(M_TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .owned          (owned),
        .host_ack_valid (host_ack_valid),
        .host_ack_id    (host_ack_id),
        .host_ack_ready (host_ack_ready),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    ack_bus_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(8)) dut_t (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req_t),
        .owned          (owned_t),
        .host_ack_valid (valid_t),
        .host_ack_id    (id_t),
        .host_ack_ready (ready_t),
        .timeout_err    (err_t),
        .err_clr        (err_clr_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; host_ack_ready = 1'b0; err_clr = 1'b0;
        req_t = '0; ready_t = 1'b0; err_clr_t = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Spec-level model: one call per clock edge with the inputs sampled there.
    task automatic model_reset();
        m_present = 0; m_gap = 0; m_gid = 0; m_ptr = 0; m_wait = 0;
        m_served = '0; m_owned = '0; m_err = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rdy, input logic clr);
        logic [3:0] elig;
        bit tmo;
        elig = r & ~m_served;
        tmo  = 0;
        m_served = m_served & r;
        m_owned  = elig;
        if (m_present) begin
            if (rdy || m_wait == M_TO - 1) begin
                tmo = !rdy;
                m_served[m_gid] = 1'b1;
                m_owned[m_gid]  = 1'b0;
                m_ptr = (m_gid + 1) % 4;
                m_present = 0;
                m_gap = 1;
            end else begin
                m_wait++;
                m_owned[m_gid] = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!m_present && elig[(m_ptr + k) % 4]) begin
                    m_present = 1;
                    m_gid = (m_ptr + k) % 4;
                    m_wait = 0;
                end
            end
        end
        m_err = (m_err && !clr) || tmo;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'hF; host_ack_ready = 1'b1; err_clr = 1'b0;
        req_t = 4'hF; ready_t = 1'b1; err_clr_t = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (owned !== 4'b0)        begin n_fail++; $display("FAIL reset_owned got %b want 0000", owned); end
        n_tests++; if (host_ack_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", host_ack_valid); end
        n_tests++; if (host_ack_id !== 2'b00) begin n_fail++; $display("FAIL reset_id got %0d want 0", host_ack_id); end
        n_tests++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b want 0", timeout_err); end
        n_tests++; if (owned_t !== 4'b0)      begin n_fail++; $display("FAIL reset_owned_t got %b want 0000", owned_t); end
        n_tests++; if (valid_t !== 1'b0)      begin n_fail++; $display("FAIL reset_valid_t got %b want 0", valid_t); end
        n_tests++; if (err_t !== 1'b0)        begin n_fail++; $display("FAIL reset_err_t got %b want 0", err_t); end
    endtask

    task automatic test_single();
        int extra;
        do_reset();
        host_ack_ready = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        n_tests++; if (host_ack_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", host_ack_valid); end
        n_tests++; if (host_ack_id !== AES_ID)  begin n_fail++; $display("FAIL single_id got %0d want 2", host_ack_id); end
        n_tests++; if (owned !== 4'b0100)       begin n_fail++; $display("FAIL single_owned_hi got %b want 0100", owned); end
        @(negedge clk);
        n_tests++; if (host_ack_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_fall got %b want 0", host_ack_valid); end
        n_tests++; if (owned !== 4'b0000)       begin n_fail++; $display("FAIL single_owned_lo got %b want 0000", owned); end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (host_ack_valid === 1'b1 || owned !== 4'b0) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL single_no_reack got %0d active cycles want 0", extra); end
        req = '0;
    endtask

    task automatic test_simultaneous();
        int         cyc[$];
        logic [1:0] ids[$];
        logic [1:0] exp_ids[3];
        exp_ids[0] = MEM_ID; exp_ids[1] = SHA_ID; exp_ids[2] = AES_ID;
        do_reset();
        host_ack_ready = 1'b1;
        req = 4'b0111;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (host_ack_valid === 1'b1) begin cyc.push_back(c); ids.push_back(host_ack_id); end
        end
        n_tests++; if (cyc.size() != 3) begin n_fail++; $display("FAIL simul_count got %0d want 3", cyc.size()); end
        if (cyc.size() >= 1) begin
            n_tests++; if (cyc[0] != 1) begin n_fail++; $display("FAIL simul_latency got %0d want 1", cyc[0]); end
        end
        for (int i = 0; i < 3 && i < ids.size(); i++) begin
            n_tests++; if (ids[i] !== exp_ids[i]) begin n_fail++; $display("FAIL simul_id[%0d] got %0d want %0d", i, ids[i], exp_ids[i]); end
            if (i > 0) begin
                n_tests++; if (cyc[i] - cyc[i-1] != 3) begin n_fail++; $display("FAIL simul_spacing[%0d] got %0d want 3", i, cyc[i] - cyc[i-1]); end
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int         cyc[$];
        logic [1:0] ids[$];
        int         exp_cyc[3];
        logic [1:0] exp_ids[3];
        exp_ids[0] = MEM_ID; exp_ids[1] = SHA_ID; exp_ids[2] = MEM_ID;
        exp_cyc[0] = 1; exp_cyc[1] = 4; exp_cyc[2] = 7;
        do_reset();
        host_ack_ready = 1'b1;
        req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (host_ack_valid === 1'b1) begin cyc.push_back(c); ids.push_back(host_ack_id); end
            if (c == 1) req = 4'b0011;   // raise SHA, MEM still high
            if (c == 2) req = 4'b0010;   // MEM drops ...
            if (c == 3) req = 4'b0011;   // ... and re-requests
        end
        n_tests++; if (ids.size() != 3) begin n_fail++; $display("FAIL fair_count got %0d want 3", ids.size()); end
        for (int i = 0; i < 3 && i < ids.size(); i++) begin
            n_tests++; if (ids[i] !== exp_ids[i]) begin n_fail++; $display("FAIL fair_id[%0d] got %0d want %0d", i, ids[i], exp_ids[i]); end
            n_tests++; if (cyc[i] != exp_cyc[i])  begin n_fail++; $display("FAIL fair_cycle[%0d] got %0d want %0d", i, cyc[i], exp_cyc[i]); end
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        int vcnt, bad_id, bad_own;
        vcnt = 0; bad_id = 0; bad_own = 0;
        do_reset();
        host_ack_ready = 1'b0;
        req = 4'b1000;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (host_ack_valid === 1'b1) begin
                vcnt++;
                if (host_ack_id !== 2'b11) bad_id++;
                if (owned !== 4'b1000) bad_own++;
            end
            if (c == 12) begin
                n_tests++; if (host_ack_valid !== 1'b0) begin n_fail++; $display("FAIL bp_complete_valid got %b want 0", host_ack_valid); end
                n_tests++; if (owned !== 4'b0000) begin n_fail++; $display("FAIL bp_complete_owned got %b want 0000", owned); end
            end
            if (c == 11) host_ack_ready = 1'b1;
        end
        n_tests++; if (vcnt != 11)   begin n_fail++; $display("FAIL bp_valid_cycles got %0d want 11", vcnt); end
        n_tests++; if (bad_id != 0)  begin n_fail++; $display("FAIL bp_id_stable got %0d bad cycles want 0", bad_id); end
        n_tests++; if (bad_own != 0) begin n_fail++; $display("FAIL bp_owned_held got %0d bad cycles want 0", bad_own); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL bp_no_err got %b want 0", timeout_err); end
        req = '0;
    endtask

    task automatic test_timeout();
        int vcnt;
        vcnt = 0;
        do_reset();
        ready_t = 1'b0;
        req_t = 4'b0010;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (valid_t === 1'b1) vcnt++;
            if (c == 8) begin
                n_tests++; if (valid_t !== 1'b1) begin n_fail++; $display("FAIL to_valid_last got %b want 1", valid_t); end
                n_tests++; if (err_t !== 1'b0)   begin n_fail++; $display("FAIL to_err_early got %b want 0", err_t); end
            end
            if (c == 9) begin
                n_tests++; if (valid_t !== 1'b0)  begin n_fail++; $display("FAIL to_valid_fall got %b want 0", valid_t); end
                n_tests++; if (err_t !== 1'b1)    begin n_fail++; $display("FAIL to_err_set got %b want 1", err_t); end
                n_tests++; if (owned_t !== 4'b0)  begin n_fail++; $display("FAIL to_owned_clr got %b want 0000", owned_t); end
            end
            if (c == 12) begin
                n_tests++; if (err_t !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b want 1", err_t); end
                err_clr_t = 1'b1;
            end
            if (c == 13) begin
                n_tests++; if (err_t !== 1'b0) begin n_fail++; $display("FAIL to_err_clr got %b want 0", err_t); end
                err_clr_t = 1'b0;
            end
        end
        n_tests++; if (vcnt != 8) begin n_fail++; $display("FAIL to_valid_cycles got %0d want 8", vcnt); end
        req_t = '0;
    endtask

    task automatic test_clr_vs_set();
        do_reset();
        ready_t = 1'b0;
        err_clr_t = 1'b1;
        req_t = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                n_tests++; if (err_t !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got %b want 1", err_t); end
            end
            if (c == 10) begin
                n_tests++; if (err_t !== 1'b0) begin n_fail++; $display("FAIL clr_after got %b want 0", err_t); end
            end
        end
        err_clr_t = 1'b0;
        req_t = '0;
    endtask

    task automatic test_reset_mid_ack();
        do_reset();
        host_ack_ready = 1'b0;
        req = 4'b0100;
        repeat (3) @(negedge clk);
        n_tests++; if (host_ack_valid !== 1'b1 || host_ack_id !== AES_ID) begin
            n_fail++; $display("FAIL midrst_pre got valid=%b id=%0d want valid=1 id=2", host_ack_valid, host_ack_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (host_ack_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", host_ack_valid); end
        n_tests++; if (host_ack_id !== 2'b00)   begin n_fail++; $display("FAIL midrst_id got %0d want 0", host_ack_id); end
        n_tests++; if (owned !== 4'b0000)       begin n_fail++; $display("FAIL midrst_owned got %b want 0000", owned); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (host_ack_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_reack_valid got %b want 1", host_ack_valid); end
        n_tests++; if (host_ack_id !== AES_ID)  begin n_fail++; $display("FAIL midrst_reack_id got %0d want 2", host_ack_id); end
        n_tests++; if (owned !== 4'b0100)       begin n_fail++; $display("FAIL midrst_reack_owned got %b want 0100", owned); end
        req = '0;
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rdy, clr;
        logic [1:0] gid;
        do_reset();
        model_reset();
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            rdy = (c >= 250 && c < 330) ? 1'b0 : 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 31) == 0);
            req = r; host_ack_ready = rdy; err_clr = clr;
            model_step(r, rdy, clr);
            @(negedge clk);
            gid = m_gid[1:0];
            n_tests++; if (host_ack_valid !== m_present) begin n_fail++; $display("FAIL rand_valid c=%0d got %b want %b", c, host_ack_valid, m_present); end
            n_tests++; if (host_ack_id !== gid)          begin n_fail++; $display("FAIL rand_id c=%0d got %0d want %0d", c, host_ack_id, gid); end
            n_tests++; if (owned !== m_owned)            begin n_fail++; $display("FAIL rand_owned c=%0d got %b want %b", c, owned, m_owned); end
            n_tests++; if (timeout_err !== m_err)        begin n_fail++; $display("FAIL rand_err c=%0d got %b want %b", c, timeout_err, m_err); end
        end
        req = '0; host_ack_ready = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; host_ack_ready = 1'b0; err_clr = 1'b0;
        req_t = '0; ready_t = 1'b0; err_clr_t = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_clr_vs_set();
        test_reset_mid_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
